// File: rtl/arm_hazard_ctrl.sv
// arm_hazard_ctrl: decode-side hazard unit for the forwarding ARM pipeline.
// Tracks in-flight writers in EX/MEM/WB and drives forwarding selects,
// load-use / flag-use stalls and the SWI halt drain sequence.
module arm_hazard_ctrl #(
    parameter int unsigned NUM_RD_PORTS = 3,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        dcd_valid,
    input  logic [NUM_RD_PORTS-1:0]     mask_of_real_read_reg,
    input  logic [4*NUM_RD_PORTS-1:0]   read_reg_num,
    input  logic                        rd_we,
    input  logic [3:0]                  rd_num,
    input  logic                        rd_data_sel,
    input  logic                        cpsr_we,
    input  logic                        uses_cpsr,
    input  logic                        halted,
    output logic                        stall,
    output logic                        fetch_en,
    output logic [2*NUM_RD_PORTS-1:0]   fwd_sel,
    output logic                        halted_out,
    output logic                        busy
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_t;

    // One in-flight instruction: valid, writes reg, dest, is load, writes flags.
    typedef struct packed {
        logic       v;
        logic       we;
        logic [3:0] rd;
        logic       ld;
        logic       cw;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{v: 1'b0, we: 1'b0, rd: 4'h0, ld: 1'b0, cw: 1'b0};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halted_out_q;
    slot_t              ex_q, mem_q, wb_q;
    slot_t              ex_d;

    logic                       run;
    logic                       load_use;
    logic                       flag_stall;
    logic                       stall_int;
    logic [2*NUM_RD_PORTS-1:0]  fwd_int;
    logic [3:0]                 rr;

    // A slot produces register r unless r is the PC, which is never forwarded.
    function automatic logic writes(input slot_t s, input logic [3:0] r);
        return s.v && s.we && (s.rd == r) && (r != 4'hF);
    endfunction

    assign run = (state_q == ST_RUN);

    // Per-port forwarding select (youngest writer wins) and load-use detection.
    always_comb begin
        fwd_int  = '0;
        load_use = 1'b0;
        rr       = 4'h0;
        for (int unsigned i = 0; i < NUM_RD_PORTS; i++) begin
            rr = read_reg_num[4*i +: 4];
            if (mask_of_real_read_reg[i] && run) begin
                if (writes(ex_q, rr)) begin
                    fwd_int[2*i +: 2] = 2'd1;
                    if (ex_q.ld) begin
                        load_use = 1'b1;
                    end
                end else if (writes(mem_q, rr)) begin
                    fwd_int[2*i +: 2] = 2'd2;
                end else if (writes(wb_q, rr)) begin
                    fwd_int[2*i +: 2] = 2'd3;
                end
            end
        end
    end

    // Stall when a dependent load or a flag producer is one stage ahead.
    always_comb begin
        flag_stall = uses_cpsr && ex_q.v && ex_q.cw;
        stall_int  = dcd_valid && run && (load_use || flag_stall);
    end

    // EX input: decoded instruction when it advances, bubble otherwise (SWI included).
    always_comb begin
        ex_d = SLOT_EMPTY;
        if (dcd_valid && run && !stall_int && !halted) begin
            ex_d.v  = 1'b1;
            ex_d.we = rd_we;
            ex_d.rd = rd_num;
            ex_d.ld = !rd_data_sel;
            ex_d.cw = cpsr_we;
        end
    end

    // Tracker shift register EX -> MEM -> WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= SLOT_EMPTY;
            mem_q <= SLOT_EMPTY;
            wb_q  <= SLOT_EMPTY;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    // Halt FSM next state: accept SWI, count the drain, then stop for good.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dcd_valid && halted && !stall_int) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_HALT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Halt FSM state, drain counter and the registered halt indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            halted_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            halted_out_q <= (state_q == ST_HALT);
        end
    end

    assign stall      = stall_int;
    assign fetch_en   = run && !stall_int && !(dcd_valid && halted);
    assign fwd_sel    = fwd_int;
    assign halted_out = halted_out_q;
    assign busy       = ex_q.v | mem_q.v | wb_q.v;

endmodule

// File: tb/tb_arm_hazard_ctrl.sv
// Self-checking bench for arm_hazard_ctrl: each cycle pushes hand-derived
// expected outputs to a scoreboard, a negedge monitor pops and compares.
module tb_arm_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dcd_valid = 1'b0;
    logic [2:0]  mask_of_real_read_reg = '0;
    logic [11:0] read_reg_num = '0;
    logic        rd_we = 1'b0;
    logic [3:0]  rd_num = '0;
    logic        rd_data_sel = 1'b1;
    logic        cpsr_we = 1'b0;
    logic        uses_cpsr = 1'b0;
    logic        halted = 1'b0;
    logic        stall;
    logic        fetch_en;
    logic [5:0]  fwd_sel;
    logic        halted_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic       st;
        logic       fe;
        logic [5:0] fwd;
        logic       ho;
        logic       bs;
    } exp_t;

    exp_t sb[$];

    arm_hazard_ctrl #(.NUM_RD_PORTS(3), .DRAIN_CYCLES(3)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .dcd_valid             (dcd_valid),
        .mask_of_real_read_reg (mask_of_real_read_reg),
        .read_reg_num          (read_reg_num),
        .rd_we                 (rd_we),
        .rd_num                (rd_num),
        .rd_data_sel           (rd_data_sel),
        .cpsr_we               (cpsr_we),
        .uses_cpsr             (uses_cpsr),
        .halted                (halted),
        .stall                 (stall),
        .fetch_en              (fetch_en),
        .fwd_sel               (fwd_sel),
        .halted_out            (halted_out),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compare outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".stall"},  8'(stall),      8'(e.st));
            chk({e.tag, ".fetch"},  8'(fetch_en),   8'(e.fe));
            chk({e.tag, ".fwd"},    8'(fwd_sel),    8'(e.fwd));
            chk({e.tag, ".halted"}, 8'(halted_out), 8'(e.ho));
            chk({e.tag, ".busy"},   8'(busy),       8'(e.bs));
        end
    end

    // Drive one decode cycle and queue the outputs expected during it.
    task automatic cyc(input string tag, input logic v, input logic [2:0] m,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic we, input logic [3:0] rd, input logic ds,
                       input logic cw, input logic uc, input logic h,
                       input logic es, input logic ef, input logic [5:0] eq,
                       input logic eh, input logic eb);
        exp_t e;
        dcd_valid             = v;
        mask_of_real_read_reg = m;
        read_reg_num          = {c, b, a};
        rd_we                 = we;
        rd_num                = rd;
        rd_data_sel           = ds;
        cpsr_we               = cw;
        uses_cpsr             = uc;
        halted                = h;
        e.tag = tag; e.st = es; e.fe = ef; e.fwd = eq; e.ho = eh; e.bs = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bub(input string tag, input logic eb);
        cyc(tag, 1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b1, 6'd0, 1'b0, eb);
    endtask

    // Three empty decode cycles; the last instruction is still in flight for all of them.
    task automatic flush(input string tag);
        for (int i = 0; i < 3; i++) bub(tag, 1'b1);
    endtask

    // ADD r1, n NOPs, SUB r2,r1,r3: port 0 must select the expected stage.
    task automatic fwd_dist(input string tag, input int n, input logic [1:0] sel);
        cyc({tag, ".add"}, 1, 3'b000, 0, 0, 0, 1, 4'd1, 1, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        for (int i = 0; i < n; i++)
            cyc({tag, ".nop"}, 1, 3'b000, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        cyc({tag, ".sub"}, 1, 3'b011, 4'd1, 4'd3, 0, 1, 4'd2, 1, 0, 0, 0,
            0, 1, {4'b0000, sel}, 0, 1);
        flush({tag, ".fl"});
    endtask

    initial begin
        @(posedge clk);
        #1;
        bub("reset", 1'b0);
        rst = 1'b0;

        fwd_dist("fwd0", 0, 2'd1);
        fwd_dist("fwd1", 1, 2'd2);
        fwd_dist("fwd2", 2, 2'd3);
        fwd_dist("fwd3", 3, 2'd0);

        // LDR r4 ; ADD r5,r4,r4
        cyc("ldr.ld",  1, 3'b000, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("ldr.use", 1, 3'b011, 4'd4, 4'd4, 0, 1, 4'd5, 1, 0, 0, 0,  1, 0, 6'b000101, 0, 1);
        cyc("ldr.fwd", 1, 3'b011, 4'd4, 4'd4, 0, 1, 4'd5, 1, 0, 0, 0,  0, 1, 6'b001010, 0, 1);
        flush("ldr.fl");

        // LDR r4 ; LDR r4 ; ADD r5,r4,r4 -- youngest load forwards
        cyc("ld2.a",   1, 3'b000, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("ld2.b",   1, 3'b000, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        cyc("ld2.use", 1, 3'b011, 4'd4, 4'd4, 0, 1, 4'd5, 1, 0, 0, 0,  1, 0, 6'b000101, 0, 1);
        cyc("ld2.fwd", 1, 3'b011, 4'd4, 4'd4, 0, 1, 4'd5, 1, 0, 0, 0,  0, 1, 6'b001010, 0, 1);
        flush("ld2.fl");

        // CMP ; MOVEQ -> flag stall
        cyc("flg.cmp", 1, 3'b000, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("flg.eq",  1, 3'b000, 0, 0, 0, 1, 4'd6, 1, 0, 1, 0,  1, 0, 6'd0, 0, 1);
        cyc("flg.go",  1, 3'b000, 0, 0, 0, 1, 4'd6, 1, 0, 1, 0,  0, 1, 6'd0, 0, 1);
        flush("flg.fl");

        // CMP ; MOV (AL) -> no stall
        cyc("al.cmp",  1, 3'b000, 0, 0, 0, 0, 4'd0, 1, 1, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("al.mov",  1, 3'b000, 0, 0, 0, 1, 4'd6, 1, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        flush("al.fl");

        // Flag-setting load then dependent conditional: still a single stall cycle
        cyc("both.ld", 1, 3'b000, 0, 0, 0, 1, 4'd4, 0, 1, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("both.s",  1, 3'b001, 4'd4, 0, 0, 1, 4'd5, 1, 0, 1, 0,  1, 0, 6'b000001, 0, 1);
        cyc("both.go", 1, 3'b001, 4'd4, 0, 0, 1, 4'd5, 1, 0, 1, 0,  0, 1, 6'b000010, 0, 1);
        flush("both.fl");

        // Load to r15 then read r15; then masked-off port matching a load in EX
        cyc("pc.ld",   1, 3'b000, 0, 0, 0, 1, 4'd15, 0, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("pc.rd",   1, 3'b001, 4'd15, 0, 0, 1, 4'd7, 0, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        cyc("mask.off",1, 3'b010, 4'd7, 4'd9, 0, 0, 4'd0, 1, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        flush("pc.fl");

        // ADD r1 ; ADD r2 ; SWI ; then junk decode that must be ignored
        cyc("h.add1",  1, 3'b000, 0, 0, 0, 1, 4'd1, 1, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("h.add2",  1, 3'b000, 0, 0, 0, 1, 4'd2, 1, 0, 0, 0,  0, 1, 6'd0, 0, 1);
        cyc("h.swi",   1, 3'b000, 0, 0, 0, 0, 4'd0, 1, 0, 0, 1,  0, 0, 6'd0, 0, 1);
        cyc("h.d1",    1, 3'b001, 4'd2, 0, 0, 1, 4'd5, 0, 1, 1, 1,  0, 0, 6'd0, 0, 1);
        cyc("h.d2",    1, 3'b001, 4'd2, 0, 0, 1, 4'd5, 0, 1, 1, 1,  0, 0, 6'd0, 0, 1);
        cyc("h.d3",    1, 3'b001, 4'd2, 0, 0, 1, 4'd5, 0, 1, 1, 1,  0, 0, 6'd0, 0, 0);
        cyc("h.d4",    1, 3'b001, 4'd2, 0, 0, 1, 4'd5, 0, 1, 1, 0,  0, 0, 6'd0, 0, 0);
        cyc("h.out",   1, 3'b001, 4'd2, 0, 0, 1, 4'd5, 0, 1, 1, 0,  0, 0, 6'd0, 1, 0);
        cyc("h.stick", 1, 3'b000, 0, 0, 0, 1, 4'd5, 1, 0, 0, 0,  0, 0, 6'd0, 1, 0);

        rst = 1'b1;
        bub("h.rst", 1'b0);
        rst = 1'b0;

        // LDR r4 ; SWI reading r4 (stalled first) ; reset while draining
        cyc("s.ld",    1, 3'b000, 0, 0, 0, 1, 4'd4, 0, 0, 0, 0,  0, 1, 6'd0, 0, 0);
        cyc("s.swi1",  1, 3'b001, 4'd4, 0, 0, 0, 4'd0, 1, 0, 0, 1,  1, 0, 6'b000001, 0, 1);
        cyc("s.swi2",  1, 3'b001, 4'd4, 0, 0, 0, 4'd0, 1, 0, 0, 1,  0, 0, 6'b000010, 0, 1);
        cyc("s.drain", 0, 3'b000, 0, 0, 0, 0, 4'd0, 1, 0, 0, 0,  0, 0, 6'd0, 0, 1);
        rst = 1'b1;
        bub("s.rst", 1'b0);
        rst = 1'b0;
        bub("s.run", 1'b0);
        fwd_dist("post", 0, 2'd1);

        @(negedge clk);
        if (sb.size() != 0) chk("sb.left", 8'(sb.size()), 8'd0);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_hazard_ctrl.md
# arm_hazard_ctrl

Pipeline hazard controller for the forwarding ARM pipeline. Sits beside the decode stage. It consumes the decoder's per-instruction control (register-read mask, read register numbers, destination/write enables, load and halt flags) and tracks in-flight writers in EX/MEM/WB. From that state it drives forwarding selects, load-use and flag-use stalls, and the SWI halt drain sequence.

## Interface
Parameters:
- NUM_RD_PORTS, 3, number of decoder read ports checked (matches mask_of_real_read_reg width)
- DRAIN_CYCLES, 3, cycles from halt acceptance to halted_out (EX+MEM+WB retire)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- dcd_valid  in  1  decode stage holds a real instruction
- mask_of_real_read_reg  in  3  bit i set: read port i is really read
- read_reg_num  in  3x4  register numbers for ports 0..2
- rd_we  in  1  instruction writes a register
- rd_num  in  4  destination register, already muxed by rd_sel
- rd_data_sel  in  1  0: load (data from memory), 1: ALU/MAC result
- cpsr_we  in  1  instruction writes CPSR flags
- uses_cpsr  in  1  instruction's condition field is not AL
- halted  in  1  decoder flags SWI
- stall  out  1  hold IF/ID, inject bubble into EX
- fetch_en  out  1  PC/IF may advance
- fwd_sel  out  3x2  per port: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- halted_out  out  1  pipeline drained after SWI, sticky until reset
- busy  out  1  any in-flight valid bit set

## Operation
- Tracker: three slots EX, MEM, WB, each holding v, we, rd[3:0], ld, cw (cpsr_we).
- Every cycle, MEM->WB and EX->MEM. WB retires.
- EX loads the decode fields when dcd_valid && !stall && state==RUN. Otherwise EX loads a bubble (v=0).
- A slot "writes r" when v && we && rd==r && r!=15.
- Forwarding, per port i with mask bit set:
  - Youngest match wins: EX, then MEM, then WB, else 0.
  - Port with mask bit clear gets fwd_sel=0.
  - r15 is never forwarded.
- Load-use stall: any masked port matches the EX slot with ld=1. The stall lasts 1 cycle. On the next cycle the load is in MEM and the port forwards with fwd_sel=2.
- Flag stall: uses_cpsr && EX.v && EX.cw. The stall lasts 1 cycle. Flags are read from the CPSR forwarded out of MEM.
- stall = dcd_valid && state==RUN && (load_use || flag_stall).
- fetch_en = state==RUN && !stall && !(dcd_valid && halted).
- Halt FSM, states RUN, DRAIN, HALT:
  - RUN->DRAIN when dcd_valid && halted && !stall. The SWI itself enters EX as a bubble and the drain counter loads DRAIN_CYCLES-1.
  - DRAIN decrements the counter each cycle. At counter==0 the FSM goes to HALT.
  - HALT is terminal.
  - In DRAIN and HALT, decode inputs are ignored and stall=0.
- busy = EX.v | MEM.v | WB.v.

## Timing
- Reset (async, immediate):
  - All slot v=0 and state=RUN.
  - Counter 0.
  - stall=0, fetch_en=1, fwd_sel=0, halted_out=0, busy=0.
- stall, fetch_en and fwd_sel are combinational from the current slots plus the decode inputs, with zero-cycle latency.
- halted_out is registered. It asserts in the cycle after the FSM enters HALT, which is DRAIN_CYCLES+1 edges after the SWI is accepted.
- Simultaneous events:
  - A stalled SWI is not accepted until the stall clears.
  - A load-use stall and a flag stall in the same cycle still give a 1-cycle stall.
- A slot matching on several ports forwards to all of them.
- Reset asserted mid-DRAIN aborts the drain and returns the FSM to RUN with an empty tracker.
- Back-to-back loads to the same rd: the youngest load wins forwarding, and the stall is evaluated only against EX.

## Test plan
- ADD r1 followed by SUB r2,r1,r3 -> no stall, fwd_sel[0]=1. With one NOP between them, fwd_sel[0]=2. With two NOPs, fwd_sel[0]=3. With three NOPs, fwd_sel[0]=0.
- LDR r4 followed by ADD r5,r4,r4 -> stall=1 for exactly 1 cycle, fetch_en=0 that cycle. Next cycle fwd_sel[0]=fwd_sel[1]=2.
- CMP followed by MOVEQ (uses_cpsr=1) -> 1-cycle stall. CMP followed by MOV with AL -> no stall.
- Write to r15, then read r15 on the next instruction -> fwd_sel=0, no stall. Port with mask bit 0 that matches EX.rd -> fwd_sel=0.
- SWI after two ALU ops -> fetch_en=0 from acceptance. halted_out rises 4 edges later, busy=0 by then, and later decode inputs are ignored.
- Assert rst during DRAIN -> all outputs return to reset values immediately, and the FSM is in RUN with fetch_en=1 after release.
